// File: rtl/sha256_stream_frontend.sv
// Stream front-end for the SHA-256 core: packs input beats into big-endian words,
// buffers them in a small FIFO, and serialises the returned digest under ready/valid.
module sha256_stream_frontend #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   din,
  input  logic              valid,
  input  logic              last,
  output logic              in_ready,
  output logic              busy,
  output logic [31:0]       w_data,
  output logic [2:0]        w_bytes,
  output logic              w_last,
  output logic              w_valid,
  input  logic              w_ready,
  input  logic [255:0]      digest,
  input  logic              digest_valid,
  output logic [OUT_W-1:0]  dout,
  output logic              dvalid,
  input  logic              dout_ready
);

  localparam int BPB    = IN_W / 8;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int NBEATS = 256 / OUT_W;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        accept;
  logic        push;
  logic        pop;
  logic        lastBeat;

  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] pack_q, pack_d;
  logic [2:0]  newCnt;
  logic [31:0] dinAligned;
  logic [31:0] mergedWord;

  logic [31:0] memData  [DEPTH];
  logic [2:0]  memBytes [DEPTH];
  logic        memLast  [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  logic [255:0]  digest_q, digest_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [255:0]  digestShift;

  assign accept   = valid && in_ready;
  assign pop      = w_valid && w_ready;
  assign lastBeat = (beat_q == BW'(NBEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && last) state_d = HASH;
      HASH:    if (digest_valid) state_d = OUT;
      OUT:     if (dout_ready && lastBeat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    dvalid   = 1'b0;
    dout     = '0;
    case (state_q)
      IDLE: begin
        in_ready = !full_q;
        busy     = 1'b0;
      end
      OUT: begin
        dvalid = 1'b1;
        dout   = digestShift[255 -: OUT_W];
      end
      default: ;
    endcase
  end

  // Packer keeps bytes left-aligned so a short final word needs no extra shifting.
  always_comb begin
    dinAligned              = '0;
    dinAligned[31 -: IN_W]  = din;
    newCnt                  = {1'b0, byteCnt_q} + 3'(BPB);
    mergedWord              = pack_q | (dinAligned >> {byteCnt_q, 3'b000});
    push                    = accept && ((newCnt == 3'd4) || last);
    pack_d                  = pack_q;
    byteCnt_d               = byteCnt_q;
    if (accept) begin
      if (push) begin
        pack_d    = '0;
        byteCnt_d = '0;
      end else begin
        pack_d    = mergedWord;
        byteCnt_d = newCnt[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pack_q    <= '0;
      byteCnt_q <= '0;
    end else begin
      pack_q    <= pack_d;
      byteCnt_q <= byteCnt_d;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset: the outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      memData[wrPtr_q]  <= push && !(newCnt == 3'd4) ? mergedWord : mergedWord;
      memBytes[wrPtr_q] <= newCnt;
      memLast[wrPtr_q]  <= last;
    end
  end

  assign w_valid = (count_q != '0);
  assign w_data  = w_valid ? memData[rdPtr_q]  : '0;
  assign w_bytes = w_valid ? memBytes[rdPtr_q] : '0;
  assign w_last  = w_valid ? memLast[rdPtr_q]  : 1'b0;

  always_comb begin
    digest_d = digest_q;
    beat_d   = beat_q;
    if (state_q == HASH && digest_valid) begin
      digest_d = digest;
      beat_d   = '0;
    end else if (state_q == OUT && dout_ready) begin
      beat_d = lastBeat ? '0 : beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digest_q <= '0;
      beat_q   <= '0;
    end else begin
      digest_q <= digest_d;
      beat_q   <= beat_d;
    end
  end

  assign digestShift = digest_q << (int'(beat_q) * OUT_W);

endmodule
